// File: rtl/ttl_bcd_down_chain.sv
// Cascaded synchronous BCD down-counter with TTL-style ENT/ENP enables, borrow out,
// zero flag and a registered pulse marking a count-driven arrival at zero.
module ttl_bcd_down_chain #(
   parameter int DIGITS       = 4,
   parameter bit STOP_AT_ZERO = 1'b0
) (
   input  logic                  Clk,
   input  logic                  Clear_bar,
   input  logic                  Load_bar,
   input  logic                  ENT,
   input  logic                  ENP,
   input  logic [4*DIGITS-1:0]   D,
   output logic [4*DIGITS-1:0]   Q,
   output logic                  BO,
   output logic                  ZERO,
   output logic                  DONE
);

   localparam int W = 4 * DIGITS;

   logic [W-1:0]        r_q;
   logic                r_done;
   logic                r_done_pend;

   logic                w_count;
   logic [DIGITS-1:0]   w_step;
   logic [W-1:0]        w_q_next;
   logic                w_zero;
   logic                w_next_zero;
   logic                w_hold_zero;

   assign w_count   = Load_bar & ENT & ENP;
   assign w_step[0] = w_count;

   // Each digit decrements only when it is stepped; the borrow to the next digit
   // comes solely from a stepped digit that was 0000, never from a binary carry.
   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      logic [3:0] w_digit;
      assign w_digit = r_q[4*g +: 4];

      assign w_q_next[4*g +: 4] = !w_step[g]                       ? w_digit :
                                  (w_digit == 4'd0 || w_digit > 4'd9) ? 4'd9    :
                                  w_digit - 4'd1;

      if (g < DIGITS - 1) begin : g_borrow
         assign w_step[g+1] = w_step[g] & (w_digit == 4'd0);
      end
   end

   assign w_zero      = (r_q == '0);
   assign w_next_zero = (w_q_next == '0);
   assign w_hold_zero = STOP_AT_ZERO && w_zero;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values and the update order inside the block does not matter.
   always_ff @(posedge Clk) begin
      if (!Clear_bar) begin
         r_q         <= '0;
         r_done_pend <= 1'b0;
         r_done      <= 1'b0;
      end else if (!Load_bar) begin
         r_q         <= D;
         r_done_pend <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= r_done_pend;
         if (w_count && !w_hold_zero) begin
            r_q         <= w_q_next;
            r_done_pend <= !w_zero && w_next_zero;
         end else begin
            r_done_pend <= 1'b0;
         end
      end
   end

   assign Q    = r_q;
   assign ZERO = w_zero;
   assign BO   = ENT & w_zero;
   assign DONE = r_done;

endmodule

// File: tb/tb_ttl_bcd_down_chain.sv
// Self-checking bench: two counters (wrap and stop-at-zero) driven in parallel and
// compared every cycle against a digit-level behavioural model.
module tb_ttl_bcd_down_chain;

   logic        clk = 1'b0;
   logic        clear_bar, load_bar, ent, enp;
   logic [15:0] d;
   logic [15:0] q0, q1;
   logic        bo0, bo1, zero0, zero1, done0, done1;

   int n_pass  = 0;
   int n_total = 0;

   logic [15:0] mq    [2];
   logic        mpend [2];
   logic        mdone [2];
   logic        m_valid = 1'b0;

   always #5 clk = ~clk;

   ttl_bcd_down_chain #(.DIGITS(4), .STOP_AT_ZERO(1'b0)) u_wrap (
      .Clk(clk), .Clear_bar(clear_bar), .Load_bar(load_bar), .ENT(ent), .ENP(enp),
      .D(d), .Q(q0), .BO(bo0), .ZERO(zero0), .DONE(done0));

   ttl_bcd_down_chain #(.DIGITS(4), .STOP_AT_ZERO(1'b1)) u_stop (
      .Clk(clk), .Clear_bar(clear_bar), .Load_bar(load_bar), .ENT(ent), .ENP(enp),
      .D(d), .Q(q1), .BO(bo1), .ZERO(zero1), .DONE(done1));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Decrement by the digit rules: walk up from digit 0 while borrows propagate.
   function automatic logic [15:0] bcd_dec(input logic [15:0] v);
      logic [15:0] r;
      logic        go;
      logic [3:0]  dg;
      r  = v;
      go = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (go) begin
            dg = r[4*i +: 4];
            if (dg > 4'd9)       begin dg = 4'd9; go = 1'b0; end
            else if (dg == 4'd0) begin dg = 4'd9;            end
            else                 begin dg = dg - 4'd1; go = 1'b0; end
            r[4*i +: 4] = dg;
         end
      end
      return r;
   endfunction

   always @(posedge clk) begin
      for (int s = 0; s < 2; s++) begin
         if (!clear_bar) begin
            mq[s] = 16'h0; mpend[s] = 1'b0; mdone[s] = 1'b0;
         end else if (!load_bar) begin
            mq[s] = d; mpend[s] = 1'b0; mdone[s] = 1'b0;
         end else begin
            mdone[s] = mpend[s];
            if (ent && enp && !(s == 1 && mq[s] == 16'h0)) begin
               logic [15:0] nxt;
               nxt      = bcd_dec(mq[s]);
               mpend[s] = (mq[s] != 16'h0) && (nxt == 16'h0);
               mq[s]    = nxt;
            end else begin
               mpend[s] = 1'b0;
            end
         end
      end
      if (!clear_bar) m_valid = 1'b1;
   end

   always @(negedge clk) begin
      if (m_valid) begin
         check("wrap_q",    {16'h0, q0},  {16'h0, mq[0]});
         check("wrap_zero", {31'h0, zero0}, {31'h0, mq[0] == 16'h0});
         check("wrap_bo",   {31'h0, bo0},   {31'h0, ent && mq[0] == 16'h0});
         check("wrap_done", {31'h0, done0}, {31'h0, mdone[0]});
         check("stop_q",    {16'h0, q1},  {16'h0, mq[1]});
         check("stop_zero", {31'h0, zero1}, {31'h0, mq[1] == 16'h0});
         check("stop_bo",   {31'h0, bo1},   {31'h0, ent && mq[1] == 16'h0});
         check("stop_done", {31'h0, done1}, {31'h0, mdone[1]});
      end
   end

   // Apply inputs just after a falling edge, return just after the next falling edge.
   task automatic cyc(input logic clr, input logic ld, input logic t, input logic p,
                      input logic [15:0] dv);
      clear_bar = clr; load_bar = ld; ent = t; enp = p; d = dv;
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   initial begin
      // 1: clear beats load and count
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 16'h1234);
      check("t1_q",    {16'h0, q0}, 32'h0000);
      check("t1_done", {31'h0, done0}, 32'h0);
      check("t1_zero", {31'h0, zero0}, 32'h1);
      check("t1_bo",   {31'h0, bo0},   32'h1);

      // 2: 0100 counts down through 0099 and 0001 to 0000
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 16'h0100);
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 16'h0);
      check("t2_q99", {16'h0, q0}, 32'h0099);
      for (int i = 0; i < 98; i++) cyc(1'b1, 1'b1, 1'b1, 1'b1, 16'h0);
      check("t2_q01", {16'h0, q0}, 32'h0001);
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 16'h0);
      check("t2_q00",   {16'h0, q0}, 32'h0000);
      check("t2_done0", {31'h0, done0}, 32'h0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
      check("t2_done1",      {31'h0, done0}, 32'h1);
      check("t2_stop_done1", {31'h0, done1}, 32'h1);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
      check("t2_done2", {31'h0, done0}, 32'h0);

      // 3: step at all-zero wraps or holds, never pulses DONE
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 16'h0);
      check("t3_wrap_q", {16'h0, q0}, 32'h9999);
      check("t3_stop_q", {16'h0, q1}, 32'h0000);
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 16'h0);
      check("t3_wrap_done", {31'h0, done0}, 32'h0);
      check("t3_stop_done", {31'h0, done1}, 32'h0);

      // 4: invalid code recovery
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 16'h00A0);
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 16'h0);
      check("t4_a0", {16'h0, q0}, 32'h0099);
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 16'h000F);
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 16'h0);
      check("t4_0f", {16'h0, q0}, 32'h0009);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h5FC9);
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 16'h0);
      check("t4_5fc9", {16'h0, q0}, 32'h5FC8);

      // 5: borrow ignores ENP, load beats count
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
      check("t5_bo_ent", {31'h0, bo0}, 32'h1);
      check("t5_hold",   {16'h0, q0},  32'h0000);
      ent = 1'b0;
      #1;
      check("t5_bo_off", {31'h0, bo0}, 32'h0);
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 16'h0005);
      check("t5_load", {16'h0, q0}, 32'h0005);

      // 6: clear on the edge that would have reached zero
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0001);
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 16'h0);
      check("t6_q", {16'h0, q0}, 32'h0000);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
      check("t6_done", {31'h0, done0}, 32'h0);

      // clear also cancels a DONE already pending
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 16'h0010);
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 16'h0);
      check("t7_q09", {16'h0, q0}, 32'h0009);
      for (int i = 0; i < 9; i++) cyc(1'b1, 1'b1, 1'b1, 1'b1, 16'h0);
      check("t7_q00", {16'h0, q0}, 32'h0000);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
      check("t7_done", {31'h0, done0}, 32'h0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
